// File: rtl/mac_result_fifo.sv
// mac_result_fifo
//   Output buffer behind the MAC datapath stage. The MAC result and its valid
//   strobe have no backpressure, so this FIFO absorbs them and hands them to a
//   valid/ready consumer. Reads are first-word-fall-through. Words that arrive
//   while the FIFO is full, with no pop in the same cycle, are dropped. Each drop
//   sets a sticky overflow flag and increments a saturating drop counter.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_data/in_valid  MAC result word and strobe (no ready returned)
//   out_data/valid    head-of-FIFO word (0 when empty) and its valid
//   out_ready         downstream accepts the head word this cycle
//   count             stored words, 0..DEPTH
//   overflow          sticky, set on any drop
//   drop_count        dropped words, saturating
//   clear_ovf         clears overflow and drop_count for one cycle
module mac_result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clear_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drop;

  logic w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the clearing cycle is counted after the clear.
      if (clear_ovf) begin
        r_ovf  <= w_drop;
        r_drop <= w_drop ? CNT_W'(1) : '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (!(&r_drop)) r_drop <= r_drop + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_result_fifo.sv
module tb_mac_result_fifo;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, clear_ovf;
  logic [19:0] in_data;
  logic [19:0] out_data;
  logic        out_valid, overflow;
  logic [3:0]  count;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_pass = 0;

  mac_result_fifo #(.WIDTH(20), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_count(drop_count),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv;
    logic [19:0] d;
    logic        rdy, clr;
    logic        ev;
    logic [19:0] ed;
    logic [3:0]  ec;
    logic        eo;
    logic [7:0]  edr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input logic [19:0] d,
                     input logic rdy, input logic clr, input logic ev,
                     input logic [19:0] ed, input logic [3:0] ec,
                     input logic eo, input logic [7:0] edr);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.edr = edr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs, clock one edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic iv, input logic [19:0] d,
                      input logic rdy, input logic clr);
    reset = rst; in_valid = iv; in_data = d; out_ready = rdy; clear_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic ev, input logic [19:0] ed,
                         input logic [3:0] ec, input logic eo, input logic [7:0] edr);
    chk({name, ".valid"}, 32'(out_valid), 32'(ev));
    chk({name, ".data"},  32'(out_data),  32'(ed));
    chk({name, ".count"}, 32'(count),     32'(ec));
    chk({name, ".ovf"},   32'(overflow),  32'(eo));
    chk({name, ".drop"},  32'(drop_count), 32'(edr));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_ovf = 1'b0;

    // Vector table: single word latency, fill/drop/drain in order, clear.
    add(0, 1, 20'h00019, 0, 0,  1, 20'h00019, 1, 0, 0);
    add(0, 0, 20'h0,     1, 0,  0, 20'h0,     0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 20'(k), 0, 0,  1, 20'h1, 4'(k), 0, 0);
    add(0, 1, 20'h9, 0, 0,  1, 20'h1, 8, 1, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 20'h0, 1, 0,  (k < 8), (k < 8) ? 20'(k + 1) : 20'h0, 4'(8 - k), 1, 1);
    add(0, 0, 20'h0, 0, 1,  0, 20'h0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_all("reset", 0, 20'h0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo, tbl[i].edr);
    end

    // Full FIFO: push with simultaneous pop is accepted, not dropped.
    for (int k = 0; k < 8; k++) step(0, 1, 20'(32'h100 + k), 0, 0);
    step(0, 1, 20'hFFFFF, 1, 0);
    chk_all("fullpp", 1, 20'h00101, 8, 0, 0);
    for (int k = 1; k < 8; k++) begin
      chk("fullpp.order", 32'(out_data), (k < 7) ? 32'h100 + k : 32'h107);
      step(0, 0, 0, 1, 0);
    end
    chk("fullpp.last", 32'(out_data), 32'hFFFFF);
    step(0, 0, 0, 1, 0);
    chk_all("fullpp.empty", 0, 20'h0, 0, 0, 0);

    // Streaming: one push and one pop per cycle, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 20'(i), 1, 0);
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d.data", i), 32'(out_data), 32'(i));
    end
    step(0, 0, 0, 1, 0);
    chk_all("stream.end", 0, 20'h0, 0, 0, 0);

    // Drop counter saturation and clear racing a drop.
    for (int k = 0; k < 8; k++) step(0, 1, 20'(32'h200 + k), 0, 0);
    for (int k = 0; k < 300; k++) step(0, 1, 20'hDEAD0, 0, 0);
    chk_all("sat", 1, 20'h00200, 8, 1, 8'd255);
    step(0, 1, 20'hDEAD1, 0, 1);
    chk_all("clr+drop", 1, 20'h00200, 8, 1, 8'd1);
    step(0, 0, 0, 0, 1);
    chk_all("clr", 1, 20'h00200, 8, 0, 8'd0);

    // Reset with 5 words stored and a push/pop in flight.
    step(0, 1, 20'hDEAD2, 0, 0);               // drop -> overflow=1
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
    chk_all("pre_rst", 1, 20'h00203, 5, 1, 8'd1);
    step(1, 1, 20'h77777, 1, 0);
    chk_all("rst5", 0, 20'h0, 0, 0, 0);
    step(0, 1, 20'hABCDE, 0, 0);
    chk_all("post_rst", 1, 20'hABCDE, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
- Output buffer directly downstream of the MAC datapath stage; consumes its 20-bit result `f` and the `valid_out` strobe.
- The MAC stage has no backpressure input, so this block decouples it from a downstream consumer that uses a valid/ready handshake.
- Results that arrive while the buffer is full are dropped and counted.
- Provides occupancy count and a sticky overflow flag for debug/monitoring.

Parameters:
- WIDTH, 20, data width of each result word; must match the MAC output width.
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  result word from the MAC stage.
- in_valid  input  1  in_data is valid this cycle; no ready is returned.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  number of stored words, range 0..DEPTH.
- overflow  output  1  sticky; set when any word has been dropped.
- drop_count  output  CNT_W  number of dropped words; saturates at all-ones.
- clear_ovf  input  1  single-cycle clear of overflow and drop_count.

Behaviour:
- Interface:
  - Clock is clk.
  - reset is synchronous and active-high.
- Reset state (reset=1 at a clock edge):
  - Read and write pointers = 0, count=0, out_valid=0, out_data=0, overflow=0, drop_count=0.
  - Storage array contents are not reset.
  - Reset overrides all other inputs, including a write or pop in flight in the same cycle; any stored words are discarded.
- Read side (first-word-fall-through):
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid=1, and 0 when the FIFO is empty.
- Pop:
  - A pop occurs when out_valid && out_ready at a clock edge; rd_ptr then advances modulo DEPTH.
  - out_ready while empty has no effect.
- Push:
  - A push occurs when in_valid=1 and either count<DEPTH, or count==DEPTH and a pop happens in the same cycle.
  - On a push, in_data is written at wr_ptr and wr_ptr advances modulo DEPTH.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N (one-cycle latency), provided the FIFO was empty.
- Count update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Drop:
  - A drop occurs when in_valid=1, count==DEPTH and there is no pop in the same cycle.
  - The word is discarded, overflow is set to 1, and drop_count increments by 1, saturating at 2^CNT_W-1.
  - Storage and pointers are unchanged by a drop.
- clear_ovf:
  - Sets overflow=0 and drop_count=0 at the edge.
  - If a drop occurs in the same cycle, the result is overflow=1 and drop_count=1; the drop is counted after the clear.
  - clear_ovf does not affect stored data, pointers or count.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are distinguished by count, not by the pointers alone.
- Data ordering is strict FIFO; words are never reordered or duplicated.
- All outputs are registered state or derived from registered state. The only combinational path from an input to an output is out_ready into the push-accept decision; there is no path from an input to any output port.

Test Plan:
- Reset, then in_valid=1 for one cycle with in_data=20'h00019 and out_ready=0 -> next cycle out_valid=1, out_data=20'h00019, count=1.
- With out_ready=0, push 8 words 1..8, then push 9 -> count=8, word 9 is dropped, overflow=1, drop_count=1; then drain with out_ready=1 -> outputs 1..8 in order, then out_valid=0 and out_data=0.
- FIFO full (8 words); in_valid=1 with in_data=20'hFFFFF and out_ready=1 in the same cycle -> no drop, count stays 8, overflow stays 0, 20'hFFFFF emerges last after draining.
- Continuous push and pop every cycle for 20 cycles with values 0..19 -> count never exceeds 1, output sequence 0..19 with one-cycle latency, pointers wrap twice without error.
- Full FIFO; drop 300 words with CNT_W=8 -> drop_count saturates at 255; then clear_ovf=1 in the same cycle as a further drop -> overflow=1, drop_count=1; next cycle clear_ovf=1 with no drop -> overflow=0, drop_count=0.
- With 5 words stored, assert reset=1 for one cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, overflow=0; the next push after reset emerges as the first output.
